posit_dot_seq: RTL
==================

Name: posit_dot_seq

Overview:
- Sequencer placed directly upstream of the posit MAC/quire unit (es=0 posit, quire accumulator).
- Accepts a dot-product job: start command with an optional bias, then a valid/ready stream of operand pairs terminated by a last flag.
- Drives the MAC control pins (PURGE, BIAS_EN, MAC_EN, RESULT_REQ_PLS) with the required timing, captures the rounded posit result and returns it on a valid/ready result port.

Parameters:
N, 8, posit width; must match the MAC unit.
CNT_W, 16, width of the product counter.

Ports:
CLK  in  1  clock
RESET  in  1  async reset, active low
START  in  1  job request; accepted when START && START_READY
START_READY  out  1  high only in IDLE
USE_BIAS  in  1  sampled with START; 1 = inject bias
BIAS_VAL  in  N  bias posit; sampled with START
ABORT  in  1  synchronous job cancel
OP_VALID  in  1  operand pair valid
OP_READY  out  1  high only in ACC
OP_A  in  N  multiplicand posit
OP_B  in  N  multiplier posit
OP_LAST  in  1  marks final pair of job
MAC_IN1  out  N  = OP_A (combinational)
MAC_IN2  out  N  = OP_B (combinational)
MAC_BIAS  out  N  registered bias value
MAC_EN  out  1  issue product to MAC
MAC_PURGE  out  1  clear MAC pipeline/quire
MAC_BIAS_EN  out  1  add bias into quire
MAC_REQ  out  1  result request pulse
MAC_OUT  in  N  MAC rounded result (valid while MAC_REQ=1)
RES_VALID  out  1  result available
RES_READY  in  1  result consumer ready
RES_DATA  out  N  captured result
RES_CNT  out  CNT_W  products accumulated in the job

Behaviour:
- Reset: state IDLE; RES_VALID=0, RES_DATA=0, RES_CNT=0, MAC_BIAS=0, bias flag=0. All MAC control pins are 0.
- States: IDLE, CLR, BIAS, ACC, DRAIN, REQ, DONE. Control pins are decoded from state and are glitch-free in the cycle they apply.
- IDLE: START_READY=1. On START, latch USE_BIAS and BIAS_VAL, clear RES_CNT, go to CLR.
- CLR: MAC_PURGE=1 for exactly one cycle. Next state is BIAS if the bias flag is set, else ACC.
- BIAS: MAC_BIAS_EN=1 for exactly one cycle, MAC_EN=0, then ACC.
  - Bias never overlaps a pending accumulate; the MAC's internal acc_en is guaranteed low here.
- ACC:
  - OP_READY=1; MAC_EN = OP_VALID.
  - On each handshake, RES_CNT increments, saturating at 2^CNT_W-1.
  - OP_VALID=0 gives a bubble: MAC_EN=0, nothing is added.
  - A handshake with OP_LAST=1 moves to DRAIN.
- DRAIN: one cycle, all control pins 0. The MAC adds its last registered product into the quire.
- REQ: MAC_REQ=1 for one cycle. RES_DATA <= MAC_OUT at the clock edge ending the cycle. Then DONE.
- DONE: RES_VALID=1, RES_DATA and RES_CNT held stable until RES_READY. On RES_VALID&&RES_READY, go to IDLE with RES_VALID=0 the next cycle.
- Minimum latency (1 pair, no bias, OP_VALID already high): START in cycle 0, CLR 1, ACC 2, DRAIN 3, REQ 4, RES_VALID in cycle 5. With bias, add 1 cycle. Each bubble adds 1 cycle.
- ABORT:
  - In CLR/BIAS/ACC/DRAIN/REQ: go to IDLE, MAC_PURGE=1 that cycle, MAC_EN=0, OP_READY=0, no result produced.
  - In DONE: the pending result is dropped.
  - In IDLE: ignored, and START in the same cycle is ignored.
  - ABORT beats every other event in the same cycle.
- START outside IDLE: ignored (START_READY=0).
- OP_VALID outside ACC: ignored; OP_READY=0 so no consumption.
- Async reset mid-job: immediate return to reset values. The MAC shares RESET, so no purge is needed.
- Jobs with zero pairs are not supported: every job ends with an OP_LAST handshake.

Test Plan:
- Single pair, no bias: OP_A=0x40 (1.0), OP_B=0x60 (2.0), OP_LAST=1.
  - Required: pulse order PURGE@1, MAC_EN@2, MAC_REQ@4.
  - Required: RES_VALID@5, RES_DATA=0x60, RES_CNT=1.
- Bias job: USE_BIAS=1, BIAS_VAL=0x20 (0.5); pair 0x40×0x20.
  - Required: MAC_BIAS_EN one cycle after PURGE, never together with MAC_EN.
  - Required: RES_DATA=0x40 (1.0), RES_CNT=1.
- Cancelling sum: pairs (0x40,0x60) then (0xC0,0x60) with LAST, one OP_VALID bubble between them.
  - Required: MAC_EN low in the bubble, RES_DATA=0x00, RES_CNT=2.
- Backpressure: hold RES_READY=0 for 10 cycles in DONE.
  - Required: RES_VALID and RES_DATA stable, START_READY=0, START pulses ignored.
  - After RES_READY=1: IDLE next cycle.
- ABORT in ACC after 3 pairs.
  - Required: MAC_PURGE=1 that cycle, no MAC_REQ, no RES_VALID, IDLE next cycle.
  - A following job of 0x40×0x40 yields 0x40.
- Assert RESET low in DRAIN.
  - Required: all outputs return to reset values asynchronously; after release START_READY=1.

Source files
------------

// File: rtl/posit_dot_seq.sv
// Job sequencer in front of the posit MAC/quire unit: sequences purge, bias, accumulate,
// drain and result request, then holds the rounded result on a valid/ready port.
module posit_dot_seq #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  output logic             START_READY,
  input  logic             USE_BIAS,
  input  logic [N-1:0]     BIAS_VAL,
  input  logic             ABORT,
  input  logic             OP_VALID,
  output logic             OP_READY,
  input  logic [N-1:0]     OP_A,
  input  logic [N-1:0]     OP_B,
  input  logic             OP_LAST,
  output logic [N-1:0]     MAC_IN1,
  output logic [N-1:0]     MAC_IN2,
  output logic [N-1:0]     MAC_BIAS,
  output logic             MAC_EN,
  output logic             MAC_PURGE,
  output logic             MAC_BIAS_EN,
  output logic             MAC_REQ,
  input  logic [N-1:0]     MAC_OUT,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [N-1:0]     RES_DATA,
  output logic [CNT_W-1:0] RES_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_BIAS,
    S_ACC,
    S_DRAIN,
    S_REQ,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             bias_flag_q, bias_flag_d;
  logic [N-1:0]     bias_q, bias_d;
  logic             res_valid_q, res_valid_d;
  logic [N-1:0]     res_data_q, res_data_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

  logic start_ready_c;
  logic op_ready_c;
  logic mac_en_c;
  logic mac_purge_c;
  logic mac_bias_en_c;
  logic mac_req_c;

  // State and job registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      bias_flag_q <= 1'b0;
      bias_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bias_flag_q <= bias_flag_d;
      bias_q      <= bias_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  // Next state, register updates and MAC control decode
  always_comb begin
    state_d       = state_q;
    bias_flag_d   = bias_flag_q;
    bias_d        = bias_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_cnt_d     = res_cnt_q;
    start_ready_c = 1'b0;
    op_ready_c    = 1'b0;
    mac_en_c      = 1'b0;
    mac_purge_c   = 1'b0;
    mac_bias_en_c = 1'b0;
    mac_req_c     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        start_ready_c = 1'b1;
        if (START && !ABORT) begin
          bias_flag_d = USE_BIAS;
          bias_d      = BIAS_VAL;
          res_cnt_d   = '0;
          state_d     = S_CLR;
        end
      end
      S_CLR: begin
        mac_purge_c = 1'b1;
        state_d     = bias_flag_q ? S_BIAS : S_ACC;
      end
      S_BIAS: begin
        mac_bias_en_c = 1'b1;
        state_d       = S_ACC;
      end
      S_ACC: begin
        op_ready_c = 1'b1;
        mac_en_c   = OP_VALID;
        if (OP_VALID) begin
          if (res_cnt_q != CNT_MAX) begin
            res_cnt_d = res_cnt_q + CNT_W'(1);
          end
          if (OP_LAST) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        mac_req_c   = 1'b1;
        res_data_d  = MAC_OUT;
        res_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (RES_READY) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cancel overrides everything outside IDLE; the quire is purged unless only a result was pending
    if (ABORT && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      res_valid_d   = 1'b0;
      res_data_d    = res_data_q;
      res_cnt_d     = res_cnt_q;
      op_ready_c    = 1'b0;
      mac_en_c      = 1'b0;
      mac_bias_en_c = 1'b0;
      mac_req_c     = 1'b0;
      mac_purge_c   = (state_q != S_DONE);
    end
  end

  assign START_READY = start_ready_c;
  assign OP_READY    = op_ready_c;
  assign MAC_IN1     = OP_A;
  assign MAC_IN2     = OP_B;
  assign MAC_BIAS    = bias_q;
  assign MAC_EN      = mac_en_c;
  assign MAC_PURGE   = mac_purge_c;
  assign MAC_BIAS_EN = mac_bias_en_c;
  assign MAC_REQ     = mac_req_c;
  assign RES_VALID   = res_valid_q;
  assign RES_DATA    = res_data_q;
  assign RES_CNT     = res_cnt_q;

endmodule
